user_id_matcher: RTL
====================

USER_ID_MATCHER -- requirements
Module: user_id_matcher

Interface
REQ-001 SHALL have parameter NUM_USERS, default 8: number of ID ROM entries (2..8).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 50000000: lockout length in clk cycles (used only under REQ-031).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Game_Enter, input, 1 bit: one-cycle digit-accept pulse, already debounced.
REQ-006 SHALL have port User_digit, input, 4 bits: BCD digit; sampled only with Game_Enter.
REQ-007 SHALL have port LogOut, input, 1 bit: logged-out flag from the password controller; its rising edge rearms this block.
REQ-008 SHALL have port Matched_ID, output, 1 bit: one-cycle pulse when the entered ID matches a ROM entry.
REQ-009 SHALL have port Internal_ID, output, 5 bits: password-ROM base address of the matched user, {index[2:0],2'b00}.
REQ-010 SHALL have port NoMatch, output, 1 bit: one-cycle pulse when a scan finds no match.
REQ-011 SHALL have port Busy, output, 1 bit: high in every state except IDLE and COLLECT.

Function
REQ-012 SHALL implement states IDLE, COLLECT, FETCH, WAIT1, WAIT2, CATCH, MATCHED, LOCKED.
REQ-013 IDLE: first Game_Enter loads the digit into a 16-bit ID shift register and sets digit count to 1; next state COLLECT.
REQ-014 COLLECT: each Game_Enter performs IdReg <= {IdReg[11:0],User_digit}; the first digit ends up most significant.
REQ-015 COLLECT: on the 4th Game_Enter, clear the scan index and go to FETCH.
REQ-016 FETCH drives the ROM address from the scan index; WAIT1 and WAIT2 are fixed wait states (2-cycle ROM latency); CATCH compares ROM data to IdReg.
REQ-017 On a CATCH match, go to MATCHED; Internal_ID <= {index,2'b00}; Matched_ID is high for exactly the one MATCHED cycle; then go to LOCKED.
REQ-018 On a CATCH mismatch with index < NUM_USERS-1, increment the index and go to FETCH.
REQ-019 On a CATCH mismatch with index = NUM_USERS-1, pulse NoMatch for the next cycle, clear IdReg and digit count, and go to IDLE.
REQ-020 Latency: 4th Game_Enter sampled at edge T; entry k's match gives Matched_ID high in cycle T+5+4k; full miss gives NoMatch high in cycle T+4*NUM_USERS+1.
REQ-021 A ROM entry equal to 16'h0000 is empty and SHALL never match; an entered ID of 0000 therefore always produces NoMatch.
REQ-022 Game_Enter SHALL be ignored while Busy=1; Game_Enter coincident with the NoMatch cycle is ignored.
REQ-023 LOCKED: ignore Game_Enter; return to IDLE on a LogOut rising edge (registered previous value 0, current 1), clearing IdReg and digit count.
REQ-024 Internal_ID SHALL hold its value until the next match; it is not cleared by NoMatch or on leaving LOCKED.
REQ-025 Matched_ID and NoMatch SHALL never be high in the same cycle.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, regardless of the current state, including mid-scan.
REQ-027 rst=0 SHALL force Matched_ID=0, NoMatch=0, Busy=0, Internal_ID=0, IdReg=0, digit count=0, scan index=0, ROM address=0, LogOut edge register=1.
REQ-028 After reset release, the first Game_Enter SHALL be accepted on the first clk edge.

Configuration
REQ-029 SHALL use the macro ID_LOCKOUT_EN.
REQ-030 Without ID_LOCKOUT_EN: NoMatch always returns the block to IDLE; no failure counter or lockout counter exists.
REQ-031 With ID_LOCKOUT_EN: a 2-bit failure counter increments on each NoMatch and clears on Matched_ID; the third consecutive NoMatch enters LOCKED for LOCKOUT_CYCLES cycles, then returns to IDLE with the counter cleared; a LogOut edge does not exit this lockout.

Structure
REQ-032 The state encoding, ID_WIDTH=16, DIGIT_WIDTH=4 and ADDR_WIDTH=5 SHALL live in the shared package orion_auth_pkg.
REQ-033 The ID table SHALL be the sub-module id_rom: 8x16-bit, registered address and output (2-cycle latency), contents from id_rom.mif.

Verification
REQ-034 ROM{0:1234, 3:0420, 5:0000, 7:9999}; enter 1,2,3,4 -> Matched_ID pulse at T+5, Internal_ID=5'd0.
REQ-035 Enter 0,4,2,0 -> Matched_ID at T+17, Internal_ID=5'd12; a LogOut 1->0->1 sequence -> IDLE, Busy=0.
REQ-036 Enter 5,5,5,5 -> NoMatch at T+33, no Matched_ID; entry 9,9,9,9 immediately after -> match, Internal_ID=5'd28.
REQ-037 Enter 0,0,0,0 -> NoMatch (empty entry 5 skipped); extra Game_Enter pulses during the scan have no effect on IdReg.
REQ-038 Assert rst during WAIT2 of entry 3 -> all outputs 0, IDLE; the next 4 digits 1,2,3,4 -> normal match.
REQ-039 With ID_LOCKOUT_EN and LOCKOUT_CYCLES=20: three wrong IDs -> Busy held 20 cycles, Game_Enter ignored, then 1,2,3,4 -> match.

Source files
------------

// File: rtl/orion_auth_pkg.sv
// Shared widths and matcher state encoding for the Orion authentication blocks.
package orion_auth_pkg;
  localparam int unsigned ID_WIDTH    = 16;
  localparam int unsigned DIGIT_WIDTH = 4;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned IDX_WIDTH   = 3;

  typedef enum logic [2:0] {
    IDLE, COLLECT, FETCH, WAIT1, WAIT2, CATCH, MATCHED, LOCKED
  } state_t;
endpackage

// File: rtl/id_rom.sv
// 8x16 user-ID table with registered address and registered data (2-cycle latency).
// Contents mirror id_rom.mif; an all-zero word marks an empty slot.
module id_rom
  import orion_auth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] addr,
  output logic [ID_WIDTH-1:0]  data
);
  logic [IDX_WIDTH-1:0] addr_q;

  function automatic logic [ID_WIDTH-1:0] rom_word(input logic [IDX_WIDTH-1:0] a);
    case (a)
      3'd0:    rom_word = 16'h1234;
      3'd3:    rom_word = 16'h0420;
      3'd5:    rom_word = 16'h0000;
      3'd7:    rom_word = 16'h9999;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data   <= '0;
    end else begin
      addr_q <= addr;
      data   <= rom_word(addr_q);
    end
  end
endmodule

// File: rtl/user_id_matcher.sv
// Collects a 4-digit BCD user ID and scans id_rom for it, reporting match or miss.
// Optional ID_LOCKOUT_EN: three consecutive misses lock the block for LOCKOUT_CYCLES.
module user_id_matcher
  import orion_auth_pkg::*;
#(
  parameter int unsigned NUM_USERS      = 8,
  parameter int unsigned LOCKOUT_CYCLES = 50000000
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Game_Enter,
  input  logic [DIGIT_WIDTH-1:0] User_digit,
  input  logic                   LogOut,
  output logic                   Matched_ID,
  output logic [ADDR_WIDTH-1:0]  Internal_ID,
  output logic                   NoMatch,
  output logic                   Busy
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_USERS - 1);

  if (NUM_USERS < 2 || NUM_USERS > 8 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("user_id_matcher: unsupported parameter set");
  end

  state_t               state;
  logic [ID_WIDTH-1:0]  id_reg;
  logic [2:0]           digit_cnt;
  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] rom_addr;
  logic [ID_WIDTH-1:0]  rom_data;
  logic                 logout_q;

`ifdef ID_LOCKOUT_EN
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [1:0]        fail_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              lockout;
`endif

  id_rom u_id_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign Busy = !(state == IDLE || state == COLLECT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      id_reg      <= '0;
      digit_cnt   <= '0;
      idx         <= '0;
      rom_addr    <= '0;
      logout_q    <= 1'b1;
      Matched_ID  <= 1'b0;
      NoMatch     <= 1'b0;
      Internal_ID <= '0;
`ifdef ID_LOCKOUT_EN
      fail_cnt    <= '0;
      lock_cnt    <= '0;
      lockout     <= 1'b0;
`endif
    end else begin
      Matched_ID <= 1'b0;
      NoMatch    <= 1'b0;
      logout_q   <= LogOut;
      case (state)
        IDLE: begin
          // A digit arriving alongside the NoMatch pulse belongs to the failed attempt.
          if (Game_Enter && !NoMatch) begin
            id_reg    <= {{(ID_WIDTH-DIGIT_WIDTH){1'b0}}, User_digit};
            digit_cnt <= 3'd1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (Game_Enter) begin
            id_reg    <= {id_reg[ID_WIDTH-DIGIT_WIDTH-1:0], User_digit};
            digit_cnt <= digit_cnt + 3'd1;
            if (digit_cnt == 3'd3) begin
              idx   <= '0;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          rom_addr <= idx;
          state    <= WAIT1;
        end
        WAIT1: state <= WAIT2;
        WAIT2: state <= CATCH;
        CATCH: begin
          if (rom_data != '0 && rom_data == id_reg) begin
            Internal_ID <= {idx, 2'b00};
            Matched_ID  <= 1'b1;
            state       <= MATCHED;
`ifdef ID_LOCKOUT_EN
            fail_cnt    <= '0;
`endif
          end else if (idx != LAST_IDX) begin
            idx   <= idx + 3'd1;
            state <= FETCH;
          end else begin
            NoMatch   <= 1'b1;
            id_reg    <= '0;
            digit_cnt <= '0;
            state     <= IDLE;
`ifdef ID_LOCKOUT_EN
            if (fail_cnt == 2'd2) begin
              lockout  <= 1'b1;
              lock_cnt <= LOCK_W'(LOCKOUT_CYCLES - 1);
              state    <= LOCKED;
            end else begin
              fail_cnt <= fail_cnt + 2'd1;
            end
`endif
          end
        end
        MATCHED: state <= LOCKED;
        LOCKED: begin
`ifdef ID_LOCKOUT_EN
          if (lockout) begin
            if (lock_cnt == '0) begin
              lockout  <= 1'b0;
              fail_cnt <= '0;
              state    <= IDLE;
            end else begin
              lock_cnt <= lock_cnt - 1'b1;
            end
          end else
`endif
          if (LogOut && !logout_q) begin
            id_reg    <= '0;
            digit_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
